startup_flash_reader: RTL

- Reader on the far side of the STARTUPE2 interface: consumes EOS and drives USRCCLKO/USRCCLKTS so user logic clocks the configuration SPI flash after startup.
- Issues SPI READ (0x03) transactions and streams bytes out on a valid/ready port for the ICAP controller to load partial bitstreams.
- Sits between the STARTUPE2 wrapper (EOS, USRCCLKO, USRCCLKTS) and the ICAP write path.

---
 rtl/startup_flash_reader.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/startup_flash_reader.sv
// Reads the configuration SPI flash through STARTUPE2 after end-of-startup
// and streams the bytes of a READ (0x03) transaction on a valid/ready port.
module startup_flash_reader #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned PRIME_CYCLES = 3,
  parameter int unsigned LEN_W        = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             eos,
  input  logic             start,
  input  logic [23:0]      start_addr,
  input  logic [LEN_W-1:0] byte_count,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             usrcclko,
  output logic             usrcclkts,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FIN_CYC = 2 * CLK_DIV;
  localparam int unsigned FIN_W   = $clog2(FIN_CYC);
  localparam int unsigned PRM_W   = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
  localparam logic [7:0]  CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    S_WAIT_EOS, S_PRIME, S_IDLE, S_CMD, S_ADDR, S_DATA, S_HOLD, S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PRM_W-1:0]   prm_q, prm_d;
  logic [FIN_W-1:0]   fin_q, fin_d;
  logic [4:0]         bit_q, bit_d;
  logic [30:0]        sh_q, sh_d;
  logic [6:0]         rx_q, rx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [7:0]         pend_data_q, pend_data_d;
  logic [7:0]         m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               sck_q, sck_d;
  logic               ts_q, ts_d;
  logic               cs_n_q, cs_n_d;
  logic               mosi_q, mosi_d;

  logic       sck_run, sck_tick, sck_rise, sck_fall, pend_load;
  logic [7:0] byte_in;

  assign sck_run   = (state_q inside {S_PRIME, S_CMD, S_ADDR, S_DATA});
  assign sck_tick  = sck_run && (div_q == DIV_W'(CLK_DIV - 1));
  assign sck_rise  = sck_tick && !sck_q;
  assign sck_fall  = sck_tick && sck_q;
  assign byte_in   = {rx_q, spi_miso};
  assign pend_load = pend_q && m_valid_q && m_ready;

  // State and datapath registers, all cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT_EOS;
      div_q       <= '0;
      prm_q       <= '0;
      fin_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      sck_q       <= 1'b0;
      ts_q        <= 1'b1;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      prm_q       <= prm_d;
      fin_q       <= fin_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      sck_q       <= sck_d;
      ts_q        <= ts_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
    end
  end

  // Next-state, SCK divider, SPI shifting and output handshake
  always_comb begin
    state_d     = state_q;
    div_d       = sck_run ? (sck_tick ? '0 : div_q + DIV_W'(1)) : '0;
    sck_d       = sck_tick ? ~sck_q : sck_q;
    prm_d       = prm_q;
    fin_d       = fin_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q && !m_ready;
    done_d      = 1'b0;
    ts_d        = ts_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;

    // A byte parked while the output was full moves out as soon as it drains
    if (pend_load) begin
      m_data_d  = pend_data_q;
      m_valid_d = 1'b1;
      pend_d    = 1'b0;
      cnt_d     = cnt_q - LEN_W'(1);
    end

    case (state_q)
      S_WAIT_EOS: begin
        if (eos) begin
          ts_d    = 1'b0;
          prm_d   = '0;
          state_d = (PRIME_CYCLES == 0) ? S_IDLE : S_PRIME;
        end
      end
      S_PRIME: begin
        if (sck_fall) begin
          prm_d = prm_q + PRM_W'(1);
          if (prm_q == PRM_W'(PRIME_CYCLES - 1)) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (start) begin
          if (byte_count == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = byte_count;
            sh_d    = {CMD_READ[6:0], start_addr};
            mosi_d  = CMD_READ[7];
            cs_n_d  = 1'b0;
            bit_d   = '0;
            state_d = S_CMD;
          end
        end
      end
      S_CMD, S_ADDR: begin
        if (sck_fall) begin
          sh_d   = {sh_q[29:0], 1'b0};
          mosi_d = sh_q[30];
          bit_d  = bit_q + 5'd1;
          if (bit_q == 5'd7) begin
            state_d = S_ADDR;
          end else if (bit_q == 5'd31) begin
            bit_d   = '0;
            mosi_d  = 1'b0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (sck_rise) begin
          rx_d = byte_in[6:0];
          if (bit_q == 5'd7) begin
            bit_d = '0;
            if (!m_valid_q || m_ready) begin
              m_data_d  = byte_in;
              m_valid_d = 1'b1;
              cnt_d     = cnt_q - LEN_W'(1);
            end else begin
              pend_d      = 1'b1;
              pend_data_d = byte_in;
            end
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
        // Pause or finish only on a falling edge so SCK always parks low
        if (sck_fall) begin
          if (pend_q && !pend_load) begin
            state_d = S_HOLD;
          end else if (cnt_d == '0) begin
            cs_n_d  = 1'b1;
            fin_d   = '0;
            state_d = S_FINISH;
          end
        end
      end
      S_HOLD: begin
        if (pend_load) begin
          if (cnt_d == '0) begin
            cs_n_d  = 1'b1;
            fin_d   = '0;
            state_d = S_FINISH;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_FINISH: begin
        fin_d = fin_q + FIN_W'(1);
        if (fin_q == FIN_W'(FIN_CYC - 2)) done_d = 1'b1;
        if (fin_q == FIN_W'(FIN_CYC - 1)) state_d = S_IDLE;
      end
      default: state_d = S_WAIT_EOS;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d inside {S_CMD, S_ADDR, S_DATA, S_HOLD, S_FINISH});
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign usrcclko  = sck_q;
  assign usrcclkts = ts_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;

endmodule
